// File: rtl/bcast_if.sv
// Packet stream into the broadcast receiver and the popped-number stream out of it.
// The receiver takes the slave modport; the mesh source and consumer take the master modport.
interface bcast_if;
    logic [15:0] i_sdata;
    logic        i_svalid;
    logic [8:0]  o_number;
    logic        o_valid;
    logic        i_ready;

    modport slave (
        input  i_sdata,
        input  i_svalid,
        input  i_ready,
        output o_number,
        output o_valid
    );

    modport master (
        output i_sdata,
        output i_svalid,
        output i_ready,
        input  o_number,
        input  o_valid
    );
endinterface

// File: rtl/bcast_receiver.sv
// Mesh broadcast receiver: filters packets by node address and queues payloads in a 4-deep FIFO.
// Optional macro BCAST_RX_RSVD_CHECK_EN rejects packets with a non-zero reserved field and flags o_err.
module bcast_receiver #(
    parameter logic [1:0] NODE_ROW = 2'd1,
    parameter logic [1:0] NODE_COL = 2'd1
) (
    input  logic       clk,
    input  logic       rst,
    bcast_if.slave     bus,
    input  logic       i_clear,
    output logic [7:0] o_rx_cnt,
    output logic [7:0] o_drop_cnt,
    output logic       o_err
);

    logic [8:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] occ;

    logic addr_match;
    logic rsvd_bad;
    logic fifo_full;
    logic fifo_empty;
    logic do_pop;
    logic do_push;
    logic do_drop;

    assign addr_match = bus.i_svalid
                      && (bus.i_sdata[15:14] == NODE_ROW)
                      && (bus.i_sdata[13:12] == NODE_COL);

`ifdef BCAST_RX_RSVD_CHECK_EN
    assign rsvd_bad = (bus.i_sdata[11:9] != 3'b000);
`else
    assign rsvd_bad = 1'b0;
`endif

    assign fifo_full  = (occ == 3'd4);
    assign fifo_empty = (occ == 3'd0);

    // An empty FIFO never pops, so a push into empty always lands and shows next cycle.
    assign do_pop  = !fifo_empty && bus.i_ready;
    assign do_push = addr_match && !rsvd_bad && (!fifo_full || do_pop);
    assign do_drop = addr_match && !rsvd_bad && fifo_full && !do_pop;

    assign bus.o_valid  = !fifo_empty;
    assign bus.o_number = fifo_empty ? 9'd0 : fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 3'd0;
        end else if (i_clear) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 3'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage needs no reset; o_number is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst && !i_clear && do_push) begin
            fifo_mem[wr_ptr] <= bus.i_sdata[8:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_rx_cnt   <= 8'd0;
            o_drop_cnt <= 8'd0;
        end else if (i_clear) begin
            o_rx_cnt   <= 8'd0;
            o_drop_cnt <= 8'd0;
        end else begin
            if (do_push && (o_rx_cnt != 8'hFF)) begin
                o_rx_cnt <= o_rx_cnt + 8'd1;
            end
            if (do_drop && (o_drop_cnt != 8'hFF)) begin
                o_drop_cnt <= o_drop_cnt + 8'd1;
            end
        end
    end

`ifdef BCAST_RX_RSVD_CHECK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (i_clear) begin
            err_q <= 1'b0;
        end else if (addr_match && rsvd_bad) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: doc/bcast_receiver.md
BCAST_RECEIVER -- requirements
Module: bcast_receiver

Interface
REQ-001 Parameter NODE_ROW, default 2'd1, 2-bit mesh row address of this node.
REQ-002 Parameter NODE_COL, default 2'd1, 2-bit mesh column address of this node.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 i_sdata  input  16  packet word: [15:14] dest row, [13:12] dest col, [11:9] reserved, [8:0] payload number.
REQ-006 i_svalid  input  1  i_sdata valid this cycle; no backpressure exists on this side.
REQ-007 i_clear  input  1  synchronous flush of FIFO, counters and error flag.
REQ-008 o_number  output  9  payload at FIFO head.
REQ-009 o_valid  output  1  FIFO non-empty; o_number valid.
REQ-010 i_ready  input  1  consumer accepts o_number when o_valid && i_ready.
REQ-011 o_rx_cnt  output  8  accepted-packet count, saturating.
REQ-012 o_drop_cnt  output  8  matching packets dropped due to full FIFO, saturating.
REQ-013 o_err  output  1  sticky reserved-field error flag.

Function
REQ-014 A packet matches when i_svalid=1 and i_sdata[15:14]==NODE_ROW and i_sdata[13:12]==NODE_COL; non-matching packets shall be ignored with no state change.
REQ-015 A matching packet shall be pushed as i_sdata[8:0] into a 4-entry FIFO; o_rx_cnt increments by 1, saturating at 255.
REQ-016 FIFO: read/write pointers of 2 bits plus a 3-bit occupancy count; pointers wrap 3->0.
REQ-017 o_valid shall be 1 exactly when occupancy>0; o_number shall be the head entry combinationally from the FIFO array.
REQ-018 Pop occurs when o_valid && i_ready; head advances next cycle; o_number is undefined-but-stable-zero when empty (drive 9'd0).
REQ-019 Push latency: matching packet in cycle N -> o_valid=1 and o_number visible in cycle N+1 if FIFO was empty.
REQ-020 Full (occupancy 4) with no pop: matching packet shall be dropped, o_drop_cnt increments (saturating at 255), o_rx_cnt unchanged.
REQ-021 Full with simultaneous pop: push shall be accepted, occupancy stays 4, no drop.
REQ-022 Empty with simultaneous push and i_ready: no pop occurs that cycle; entry appears next cycle.
REQ-023 Simultaneous push and pop at non-boundary occupancy: occupancy unchanged, both pointers advance.
REQ-024 i_clear=1 shall, next cycle, empty the FIFO, zero o_rx_cnt, o_drop_cnt, o_err; a push or pop in the same cycle is discarded.
REQ-025 Receiver is stateless across bursts: any number of packets, in any order, with gaps, shall be handled identically.

Reset
REQ-026 With rst=0 at a rising edge: pointers and occupancy 0, o_valid=0, o_number=0, o_rx_cnt=0, o_drop_cnt=0, o_err=0.
REQ-027 Reset shall take priority over i_clear, push and pop; reset mid-burst discards all buffered entries.

Configuration
REQ-028 Macro BCAST_RX_RSVD_CHECK_EN defined: a matching packet with i_sdata[11:9]!=3'b000 shall be discarded (not pushed, not counted) and o_err set to 1 until i_clear or reset.
REQ-029 Macro BCAST_RX_RSVD_CHECK_EN undefined: bits [11:9] ignored, such packets accepted normally, o_err tied to 0.

Verification
REQ-030 NODE=(1,1); send dest 01_01 num 9'h1A5 with i_ready=0 -> next cycle o_valid=1, o_number=9'h1A5, o_rx_cnt=1.
REQ-031 NODE=(1,1); send sequence of 8 packets to dests 01,10,0100,0101,0110,1000,1001,1010 num 9'd77 -> exactly one entry 77, o_rx_cnt=1.
REQ-032 i_ready=0; push 6 matching packets 1..6 -> o_drop_cnt=2, FIFO yields 1,2,3,4 in order after i_ready=1, then o_valid=0.
REQ-033 FIFO full, i_ready=1 and matching packet 9'd300 same cycle -> o_drop_cnt unchanged, 300 emerges fifth.
REQ-034 With BCAST_RX_RSVD_CHECK_EN: matching packet 16'h5E01 -> not pushed, o_err=1; i_clear pulse -> o_err=0, counters 0; without macro same packet -> o_number=9'h001.
REQ-035 Push 3 entries, assert rst=0 one cycle -> o_valid=0, all counters 0; next matching packet appears alone.
